// File: rtl/mem_write_buffer_pkg.sv
// rtl/mem_write_buffer_pkg.sv - shared state encodings and entry sizing for the posted-write store buffer
package mem_write_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } wb_state_e;

    // One buffered store is {word address, data}; byte offset bits are dropped.
    function automatic int entry_width(input int addr_w, input int data_w);
        return addr_w - 2 + data_w;
    endfunction

endpackage

// File: rtl/write_buffer_fifo.sv
// rtl/write_buffer_fifo.sv - circular store FIFO with youngest-match address lookup
//
// Ports:
//   clk, Reset               clock, asynchronous active-high reset
//   push, push_addr/data     enqueue one store at tail
//   pop                      retire head entry
//   head_addr, head_data     oldest entry (drain candidate)
//   lookup_addr              load word address to search for
//   hit, hit_data            youngest valid entry matching lookup_addr
//   empty, full, count       occupancy
module write_buffer_fifo
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         push,
    input  logic [ADDR_W-3:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [ADDR_W-3:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    input  logic [ADDR_W-3:0]            lookup_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            hit_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int EW = entry_width(ADDR_W, DATA_W);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [EW-1:0] entry_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] idx;

    // Entry validity is implied by position relative to head and count,
    // so the payload array needs no reset.
    always_ff @(posedge clk) begin
        if (push && !Reset) begin
            entry_q[tail_q] <= {push_addr, push_data};
        end
    end

    // When full, a push coinciding with a pop overwrites the slot being
    // retired; the head entry has already been accepted by memory.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk from oldest to youngest; later matches override earlier ones so
    // the result is the youngest matching store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (entry_q[idx][EW-1:DATA_W] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entry_q[idx][DATA_W-1:0];
            end
        end
    end

    assign head_addr = entry_q[head_q][EW-1:DATA_W];
    assign head_data = entry_q[head_q][DATA_W-1:0];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;

endmodule

// File: rtl/mem_write_buffer.sv
// rtl/mem_write_buffer.sv - posted-write store buffer between MEM stage and a req/ack data memory
//
// Ports:
//   clk, Reset                         clock, asynchronous active-high reset
//   cpu_we, cpu_re, cpu_addr,          MEM-stage store/load request (byte address)
//   cpu_wdata, cpu_rdata, cpu_stall    store data, load data, pipeline freeze
//   mem_req, mem_we, mem_addr,         memory request (word address), held until mem_ack
//   mem_wdata, mem_rdata, mem_ack
//   empty, full, count                 buffer occupancy
module mem_write_buffer
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         cpu_we,
    input  logic                         cpu_re,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_stall,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ack,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    wb_state_e          state_q, state_d;
    logic [ADDR_W-3:0]  read_addr_q;
    logic [ADDR_W-3:0]  word_addr;
    logic [ADDR_W-3:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic [DATA_W-1:0]  hit_data;
    logic               hit;
    logic               load_req, store_req, load_miss;
    logic               write_ack, read_ack;
    logic               push, pop;
    logic               unused_byte_off;

    assign word_addr       = cpu_addr[ADDR_W-1:2];
    assign unused_byte_off = ^cpu_addr[1:0];

    // A simultaneous store and load is treated as a load only.
    assign load_req  = cpu_re;
    assign store_req = cpu_we & ~cpu_re;
    assign load_miss = load_req & ~hit;

    assign write_ack = (state_q == ST_WRITE) & mem_ack;
    assign read_ack  = (state_q == ST_READ)  & mem_ack;

    // A full buffer still accepts a store on the cycle the head write retires.
    assign pop  = write_ack;
    assign push = store_req & (~full | write_ack);

    write_buffer_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .Reset       (Reset),
        .push        (push),
        .push_addr   (word_addr),
        .push_data   (cpu_wdata),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .lookup_addr (word_addr),
        .hit         (hit),
        .hit_data    (hit_data),
        .empty       (empty),
        .full        (full),
        .count       (count)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            read_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && load_miss) begin
                read_addr_q <= word_addr;
            end
        end
    end

    // Load misses win over draining; a miss that arrives mid-write waits
    // for that write to finish and is picked up on the following IDLE cycle.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (load_miss)   state_d = ST_READ;
                else if (!empty) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {2'b00, head_addr};
                mem_wdata = head_data;
                if (mem_ack) state_d = ST_IDLE;
            end
            ST_READ: begin
                mem_req  = 1'b1;
                mem_addr = {2'b00, read_addr_q};
                if (mem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_rdata = '0;
        if (load_req && hit)           cpu_rdata = hit_data;
        else if (load_req && read_ack) cpu_rdata = mem_rdata;
    end

    assign cpu_stall = ~Reset & ((store_req & full & ~write_ack) |
                                 (load_miss & ~read_ack));

endmodule

// File: tb/tb_mem_write_buffer.sv
// tb/tb_mem_write_buffer.sv - scoreboard bench for mem_write_buffer
module tb_mem_write_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              Reset;
    logic              cpu_we, cpu_re;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              empty, full;
    logic [CW-1:0]     count;

    int errors = 0;
    int checks = 0;

    logic [63:0] wq [$];
    logic [31:0] rq [$];
    logic [63:0] exp_w;
    logic [31:0] exp_r;

    always #5 clk = ~clk;

    mem_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Completed memory transactions are compared against the scoreboard.
    always @(negedge clk) begin
        if (!Reset && mem_req && mem_ack) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_w = wq.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(exp_w[63:32]));
                    chk("wr_data", 64'(mem_wdata), 64'(exp_w[31:0]));
                end
            end else begin
                if (rq.size() == 0) begin
                    chk("unexpected_read", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_r = rq.pop_front();
                    chk("rd_addr", 64'(mem_addr), 64'(exp_r));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        wq.delete();
        rq.delete();
        Reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_re    = 1'b0;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic drain(input string tag);
        int n;
        n       = 0;
        cpu_we  = 1'b0;
        cpu_re  = 1'b0;
        mem_ack = 1'b1;
        while (!(empty && !mem_req) && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_wq_left"}, 64'(wq.size()), 64'd0);
        mem_ack = 1'b0;
    endtask

    initial begin
        // reset state, with a would-be load miss held during reset
        Reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h300;
        cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        sample();
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_req",   64'(mem_req),   64'd0);
        chk("rst_empty", 64'(empty),     64'd1);
        chk("rst_full",  64'(full),      64'd0);
        chk("rst_count", 64'(count),     64'd0);
        chk("rst_rdata", 64'(cpu_rdata), 64'd0);
        tick();
        Reset = 1'b0; cpu_re = 1'b0;

        // 1: stores drain in order with ack tied high
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            store(32'h10 + 32'(4*i), 32'hA + 32'(i));
            wq.push_back({32'(4 + i), 32'hA + 32'(i)});
            sample();
            chk("t1_stall", 64'(cpu_stall), 64'd0);
            tick();
        end
        drain("t1");

        // 2: fill to DEPTH, fifth store stalls until head write acks
        do_reset();
        for (int i = 0; i < 4; i++) begin
            store(32'h100 + 32'(4*i), 32'h100 + 32'(i));
            wq.push_back({32'h40 + 32'(i), 32'h100 + 32'(i)});
            sample();
            chk("t2_stall_acc", 64'(cpu_stall), 64'd0);
            tick();
        end
        store(32'h110, 32'h104);
        sample();
        chk("t2_stall_full", 64'(cpu_stall), 64'd1);
        chk("t2_full",       64'(full),      64'd1);
        chk("t2_count",      64'(count),     64'd4);
        tick();
        sample();
        chk("t2_stall_hold", 64'(cpu_stall), 64'd1);
        tick();
        mem_ack = 1'b1;
        wq.push_back({32'h44, 32'h104});
        sample();
        chk("t2_stall_ack", 64'(cpu_stall), 64'd0);
        tick();
        cpu_we = 1'b0; mem_ack = 1'b0;
        sample();
        chk("t2_count_after", 64'(count), 64'd4);
        chk("t2_full_after",  64'(full),  64'd1);
        tick();
        drain("t2");

        // 3: youngest-match forwarding; simultaneous we/re acts as a load
        do_reset();
        store(32'h20, 32'h11); wq.push_back({32'h8, 32'h11}); tick();
        store(32'h20, 32'h22); wq.push_back({32'h8, 32'h22}); tick();
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h20;
        sample();
        chk("t3_rdata",  64'(cpu_rdata), 64'h22);
        chk("t3_stall",  64'(cpu_stall), 64'd0);
        chk("t3_mem_we", 64'(mem_we),    64'd1);
        tick();
        cpu_we = 1'b1; cpu_wdata = 32'h99;
        sample();
        chk("t3_both_rdata", 64'(cpu_rdata), 64'h22);
        chk("t3_both_stall", 64'(cpu_stall), 64'd0);
        tick();
        cpu_we = 1'b0; cpu_re = 1'b0;
        sample();
        chk("t3_count", 64'(count), 64'd2);
        tick();
        drain("t3");

        // 4: load miss on empty buffer, ack three cycles after req
        do_reset();
        cpu_re = 1'b1; cpu_addr = 32'h40;
        rq.push_back(32'h10);
        sample();
        chk("t4_stall_c0", 64'(cpu_stall), 64'd1);
        chk("t4_req_c0",   64'(mem_req),   64'd0);
        tick();
        sample();
        chk("t4_req",   64'(mem_req),   64'd1);
        chk("t4_we",    64'(mem_we),    64'd0);
        chk("t4_addr",  64'(mem_addr),  64'h10);
        chk("t4_stall", 64'(cpu_stall), 64'd1);
        tick();
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("t4_stall_wait", 64'(cpu_stall), 64'd1);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD;
        sample();
        chk("t4_stall_ack", 64'(cpu_stall), 64'd0);
        chk("t4_rdata",     64'(cpu_rdata), 64'hDEAD);
        tick();
        cpu_re = 1'b0; mem_ack = 1'b0;
        sample();
        chk("t4_rq_left", 64'(rq.size()), 64'd0);
        tick();

        // 5: load miss while a write is in flight
        do_reset();
        store(32'h50, 32'h55); wq.push_back({32'h14, 32'h55}); tick();
        cpu_we = 1'b0; tick();
        cpu_re = 1'b1; cpu_addr = 32'h60;
        rq.push_back(32'h18);
        sample();
        chk("t5_stall_w",  64'(cpu_stall), 64'd1);
        chk("t5_we_w",     64'(mem_we),    64'd1);
        chk("t5_addr_w",   64'(mem_addr),  64'h14);
        tick();
        sample();
        chk("t5_stall_w2", 64'(cpu_stall), 64'd1);
        tick();
        mem_ack = 1'b1;
        sample();
        chk("t5_stall_wack", 64'(cpu_stall), 64'd1);
        tick();
        mem_ack = 1'b0;
        sample();
        chk("t5_stall_idle", 64'(cpu_stall), 64'd1);
        tick();
        sample();
        chk("t5_we_r",    64'(mem_we),    64'd0);
        chk("t5_addr_r",  64'(mem_addr),  64'h18);
        chk("t5_stall_r", 64'(cpu_stall), 64'd1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hBEEF;
        sample();
        chk("t5_stall_ack", 64'(cpu_stall), 64'd0);
        chk("t5_rdata",     64'(cpu_rdata), 64'hBEEF);
        tick();
        cpu_re = 1'b0; mem_ack = 1'b0;
        sample();
        chk("t5_wq_left", 64'(wq.size()), 64'd0);
        chk("t5_rq_left", 64'(rq.size()), 64'd0);
        tick();

        // 6: reset mid-WRITE discards buffered stores
        do_reset();
        store(32'h70, 32'h1); tick();
        store(32'h74, 32'h2); tick();
        cpu_we = 1'b0;
        sample();
        chk("t6_req_pre",   64'(mem_req), 64'd1);
        chk("t6_count_pre", 64'(count),   64'd2);
        tick();
        Reset = 1'b1; cpu_re = 1'b1; cpu_addr = 32'h200;
        sample();
        chk("t6_req",   64'(mem_req),   64'd0);
        chk("t6_count", 64'(count),     64'd0);
        chk("t6_empty", 64'(empty),     64'd1);
        chk("t6_stall", 64'(cpu_stall), 64'd0);
        tick();
        Reset = 1'b0; cpu_re = 1'b0;
        tick();
        sample();
        chk("t6_req_post",   64'(mem_req), 64'd0);
        chk("t6_empty_post", 64'(empty),   64'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
Posted-write store buffer between the MEM stage and data memory. MEM-stage stores enqueue without waiting for memory. Loads that hit a buffered address are forwarded in the same cycle; loads that miss are issued to memory with priority over draining. Stalls the pipeline only on load miss or buffer-full store. Data memory becomes a req/ack port with variable latency.

Parameters:
DEPTH, 4, number of buffered stores (power of two, >=2)
DATA_W, 32, data width
ADDR_W, 32, CPU byte-address width

Ports:
clk  in  1  clock
Reset  in  1  reset (decided: one clock; reset asynchronous, active-high)
cpu_we  in  1  store request (MEM-stage MemWrite)
cpu_re  in  1  load request (MEM-stage MemtoReg)
cpu_addr  in  ADDR_W  byte address (MEM-stage ALU result)
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data
cpu_stall  out  1  freeze PC/IF/ID/EX/MEM this cycle
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word address (byte address >> 2)
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid with mem_ack on a read
mem_ack  in  1  request completes this cycle (may arrive in the first req cycle)
empty  out  1  no valid entries (top gates stop on this)
full  out  1  count == DEPTH
count  out  $clog2(DEPTH+1)  valid entries

Behaviour:
- Reset (async): all entries invalid; head, tail, count = 0; state IDLE; mem_req = 0; cpu_rdata = 0. cpu_stall is forced 0 while Reset is high.
- Reset mid-transaction: the in-flight request is abandoned and buffered stores are discarded.
- Entry contents: {word address = cpu_addr[ADDR_W-1:2], data}. Circular FIFO; head/tail wrap modulo DEPTH.
- Store, not full: enqueue at the clock edge; cpu_stall = 0; no coalescing (duplicate addresses allowed).
- Store, full: cpu_stall = 1 and no enqueue.
  - Exception: if the head write acks in the same cycle, the store is accepted at that edge (pop + push), cpu_stall = 0 and count is unchanged.
- Load hit (any valid entry, including the in-flight head, matches the word address): cpu_rdata = data of the youngest matching entry, combinational, cpu_stall = 0.
- Load miss: cpu_stall = 1 until the read ack. On the ack cycle, cpu_rdata = mem_rdata and cpu_stall = 0.
  - Minimum stall is 1 cycle (req cycle N+1 with immediate ack).
- cpu_we and cpu_re are never both high. If they are, cpu_we is ignored.
- FSM (states IDLE, WRITE, READ; mem_req = state != IDLE):
  - IDLE: a load miss goes to READ. Otherwise, if not empty, go to WRITE. Load miss has priority over drain.
  - WRITE: mem_we = 1, addr/data = head entry, held stable until ack. On ack: pop head; go to IDLE.
  - READ: mem_we = 0, addr = latched load word address, held until ack. On ack go to IDLE.
  - A load miss arriving during WRITE stalls until the write acks, then goes IDLE -> READ.
- Reads bypassing older buffered writes is safe: the read goes to memory only when no buffered entry matches its address.
- mem_wdata = 0 when not in WRITE.
- full/empty/count update at the clock edge.

Decomposition:
- Shared package: state encodings (IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2) and the entry-width constant (ADDR_W-2+DATA_W).
- One sub-module, write_buffer_fifo. It holds the storage, pointers and count, plus the youngest-match search logic. The parent holds the FSM, memory port and stall logic.

Test Plan:
1. Reset; with mem_ack tied 1, store 0x10<-0xA, 0x14<-0xB, 0x18<-0xC on consecutive cycles -> memory writes occur in order to addresses 4, 5, 6 with the matching data; cpu_stall never 1; empty = 1 at the end.
2. With mem_ack = 0, issue five stores (DEPTH = 4) -> full = 1, count = 4, 5th store held with cpu_stall = 1. Pulse mem_ack one cycle -> 5th store accepted at that edge, count stays 4, stall drops.
3. With mem_ack = 0, store 0x20<-0x11 then 0x20<-0x22, then load 0x20 -> cpu_rdata = 0x22 in the same cycle, cpu_stall = 0, no read issued.
4. Empty buffer; load 0x40; memory acks 3 cycles after req with 0xDEAD -> mem_we = 0, mem_addr = 0x10; cpu_stall high until the ack cycle; cpu_rdata = 0xDEAD on the ack cycle.
5. While a write to 0x50 is in flight, load 0x60 (miss) -> stall persists, write acks first, read to 0x18 is then issued; load returns memory data.
6. Assert Reset mid-WRITE with 2 entries buffered -> mem_req drops immediately, count = 0, empty = 1, cpu_stall = 0.
